// File: rtl/ex_mem_pkg.sv
// Shared widths, opcodes and stall-vector indices for the MIPS pipeline registers.
package ex_mem_pkg;
  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int AluOpBus     = 8;
  localparam int DoubleRegBus = 64;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/stall handling and MADD/MSUB accumulator feedback.
// Optional bubble counter output enabled by EX_MEM_BUBBLE_CNT_EN.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W    = RegBus,
  parameter int ALUOP_W   = AluOpBus,
  parameter int REGADDR_W = RegAddrBus
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [REGADDR_W-1:0] ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic                 ex_whilo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic                 ex_cp0_reg_we,
  input  logic [4:0]           ex_cp0_reg_write_addr,
  input  logic [DATA_W-1:0]    ex_cp0_reg_data,
  input  logic [31:0]          ex_excepttype,
  input  logic                 ex_is_in_delayslot,
  input  logic [DATA_W-1:0]    ex_current_inst_address,
  input  logic [2*DATA_W-1:0]  hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [REGADDR_W-1:0] mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic                 mem_whilo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic                 mem_cp0_reg_we,
  output logic [4:0]           mem_cp0_reg_write_addr,
  output logic [DATA_W-1:0]    mem_cp0_reg_data,
  output logic [31:0]          mem_excepttype,
  output logic                 mem_is_in_delayslot,
  output logic [DATA_W-1:0]    mem_current_inst_address,
  output logic [2*DATA_W-1:0]  hilo_o,
  output logic [1:0]           cnt_o
`ifdef EX_MEM_BUBBLE_CNT_EN
  ,
  output logic [31:0]          bubble_cnt_o
`endif
);

  typedef struct packed {
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
    logic                 whilo;
    logic [ALUOP_W-1:0]   aluop;
    logic [DATA_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    reg2;
    logic                 cp0_we;
    logic [4:0]           cp0_addr;
    logic [DATA_W-1:0]    cp0_data;
    logic [31:0]          exc;
    logic                 ds;
    logic [DATA_W-1:0]    pc;
  } stage_t;

  stage_t              r_mem;
  stage_t              w_ex;
  stage_t              w_bubble;
  logic [2*DATA_W-1:0] r_hilo;
  logic [1:0]          r_cnt;
  logic                w_ex_bubble;
  logic                w_load;
  logic                w_unused;

  assign w_unused = ^{stall[5], stall[2:0]};

  // EX stalled while MEM still advances: MEM must see a bubble, not a duplicate.
  assign w_ex_bubble = (stall[STALL_EX] == Stop) && (stall[STALL_MEM] == NoStop);
  assign w_load      = (stall[STALL_EX] == NoStop);

  always_comb begin
    w_ex = '{
      wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
      whilo: ex_whilo, aluop: ex_aluop, mem_addr: ex_mem_addr, reg2: ex_reg2,
      cp0_we: ex_cp0_reg_we, cp0_addr: ex_cp0_reg_write_addr,
      cp0_data: ex_cp0_reg_data, exc: ex_excepttype, ds: ex_is_in_delayslot,
      pc: ex_current_inst_address
    };
    w_bubble        = '0;
    w_bubble.aluop  = EXE_NOP_OP;
    w_bubble.wreg   = WriteDisable;
    w_bubble.whilo  = WriteDisable;
    w_bubble.cp0_we = WriteDisable;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem  <= '0;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_mem  <= w_bubble;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (w_ex_bubble) begin
      // Accumulator survives the EX stall so EX can finish the second phase.
      r_mem  <= w_bubble;
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end else if (w_load) begin
      r_mem  <= w_ex;
      r_hilo <= '0;
      r_cnt  <= '0;
    end
  end

`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_bubble_cnt <= '0;
    else if (flush || w_ex_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  assign mem_wd                   = r_mem.wd;
  assign mem_wreg                 = r_mem.wreg;
  assign mem_wdata                = r_mem.wdata;
  assign mem_hi                   = r_mem.hi;
  assign mem_lo                   = r_mem.lo;
  assign mem_whilo                = r_mem.whilo;
  assign mem_aluop                = r_mem.aluop;
  assign mem_mem_addr             = r_mem.mem_addr;
  assign mem_reg2                 = r_mem.reg2;
  assign mem_cp0_reg_we           = r_mem.cp0_we;
  assign mem_cp0_reg_write_addr   = r_mem.cp0_addr;
  assign mem_cp0_reg_data         = r_mem.cp0_data;
  assign mem_excepttype           = r_mem.exc;
  assign mem_is_in_delayslot      = r_mem.ds;
  assign mem_current_inst_address = r_mem.pc;
  assign hilo_o                   = r_hilo;
  assign cnt_o                    = r_cnt;

endmodule

// File: tb/tb_ex_mem.sv
// Directed scoreboard bench for ex_mem: expected outputs are queued as each step is driven.
module tb_ex_mem;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr, ex_reg2;
  logic        ex_cp0_reg_we;
  logic [4:0]  ex_cp0_reg_write_addr;
  logic [31:0] ex_cp0_reg_data, ex_excepttype;
  logic        ex_is_in_delayslot;
  logic [31:0] ex_current_inst_address;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic        mem_cp0_reg_we;
  logic [4:0]  mem_cp0_reg_write_addr;
  logic [31:0] mem_cp0_reg_data, mem_excepttype;
  logic        mem_is_in_delayslot;
  logic [31:0] mem_current_inst_address;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_o;
`endif

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata, hi, lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_data, exc;
    logic        ds;
    logic [31:0] pc;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_bc = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .ex_cp0_reg_we(ex_cp0_reg_we), .ex_cp0_reg_write_addr(ex_cp0_reg_write_addr),
    .ex_cp0_reg_data(ex_cp0_reg_data), .ex_excepttype(ex_excepttype),
    .ex_is_in_delayslot(ex_is_in_delayslot), .ex_current_inst_address(ex_current_inst_address),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_cp0_reg_we(mem_cp0_reg_we),
    .mem_cp0_reg_write_addr(mem_cp0_reg_write_addr), .mem_cp0_reg_data(mem_cp0_reg_data),
    .mem_excepttype(mem_excepttype), .mem_is_in_delayslot(mem_is_in_delayslot),
    .mem_current_inst_address(mem_current_inst_address), .hilo_o(hilo_o), .cnt_o(cnt_o)
`ifdef EX_MEM_BUBBLE_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ex(input logic [31:0] s, input logic [4:0] wd);
    ex_wd = wd; ex_wreg = 1'b1; ex_wdata = s; ex_hi = ~s; ex_lo = s + 32'd1;
    ex_whilo = 1'b1; ex_aluop = s[7:0]; ex_mem_addr = s << 2; ex_reg2 = s ^ 32'hA5A5_A5A5;
    ex_cp0_reg_we = 1'b1; ex_cp0_reg_write_addr = s[9:5]; ex_cp0_reg_data = s + 32'd2;
    ex_excepttype = s & 32'h0000_FFFF; ex_is_in_delayslot = s[0];
    ex_current_inst_address = s & ~32'h3;
  endtask

  function automatic exp_t pass(input logic [31:0] s, input logic [4:0] wd);
    exp_t e;
    e.wd = wd; e.wreg = 1'b1; e.wdata = s; e.hi = ~s; e.lo = s + 32'd1; e.whilo = 1'b1;
    e.aluop = s[7:0]; e.addr = s << 2; e.reg2 = s ^ 32'hA5A5_A5A5; e.cp0_we = 1'b1;
    e.cp0_addr = s[9:5]; e.cp0_data = s + 32'd2; e.exc = s & 32'h0000_FFFF; e.ds = s[0];
    e.pc = s & ~32'h3; e.hilo = 64'h0; e.cnt = 2'b00;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [63:0] h, input logic [1:0] c);
    exp_t e;
    e.wd = '0; e.wreg = 1'b0; e.wdata = '0; e.hi = '0; e.lo = '0; e.whilo = 1'b0;
    e.aluop = '0; e.addr = '0; e.reg2 = '0; e.cp0_we = 1'b0; e.cp0_addr = '0;
    e.cp0_data = '0; e.exc = '0; e.ds = 1'b0; e.pc = '0; e.hilo = h; e.cnt = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vecs++; errs++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      return;
    end
    e = sb.pop_front();
    last = e;
    chk({tag, ".wd"},       64'(mem_wd), 64'(e.wd));
    chk({tag, ".wreg"},     64'(mem_wreg), 64'(e.wreg));
    chk({tag, ".wdata"},    64'(mem_wdata), 64'(e.wdata));
    chk({tag, ".hi"},       64'(mem_hi), 64'(e.hi));
    chk({tag, ".lo"},       64'(mem_lo), 64'(e.lo));
    chk({tag, ".whilo"},    64'(mem_whilo), 64'(e.whilo));
    chk({tag, ".aluop"},    64'(mem_aluop), 64'(e.aluop));
    chk({tag, ".addr"},     64'(mem_mem_addr), 64'(e.addr));
    chk({tag, ".reg2"},     64'(mem_reg2), 64'(e.reg2));
    chk({tag, ".cp0_we"},   64'(mem_cp0_reg_we), 64'(e.cp0_we));
    chk({tag, ".cp0_addr"}, 64'(mem_cp0_reg_write_addr), 64'(e.cp0_addr));
    chk({tag, ".cp0_data"}, 64'(mem_cp0_reg_data), 64'(e.cp0_data));
    chk({tag, ".exc"},      64'(mem_excepttype), 64'(e.exc));
    chk({tag, ".ds"},       64'(mem_is_in_delayslot), 64'(e.ds));
    chk({tag, ".pc"},       64'(mem_current_inst_address), 64'(e.pc));
    chk({tag, ".hilo"},     hilo_o, e.hilo);
    chk({tag, ".cnt"},      64'(cnt_o), 64'(e.cnt));
`ifdef EX_MEM_BUBBLE_CNT_EN
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'(exp_bc));
`endif
  endtask

  // One clock edge: drive controls, queue the expectation, sample 1ns after the edge.
  task automatic step(input string tag, input logic [5:0] st, input logic fl, input exp_t e);
    stall = st;
    flush = fl;
    sb.push_back(e);
    if (fl || (st[3] && !st[4])) exp_bc = exp_bc + 32'd1;
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; hilo_i = '0; cnt_i = '0;
    set_ex(32'h0, 5'd0);
    #1 rst = 1'b0;
    #1;
    exp_bc = 0;
    sb.push_back(bubble(64'h0, 2'b00));
    compare("reset");
    @(posedge clk); #1 rst = 1'b1;

    set_ex(32'h1234_5678, 5'd5);
    step("pass1", 6'b000000, 1'b0, pass(32'h1234_5678, 5'd5));
    set_ex(32'hDEAD_BEEF, 5'd31);
    step("pass2", 6'b000000, 1'b0, pass(32'hDEAD_BEEF, 5'd31));

    // MADD/MSUB phase 1 then release
    set_ex(32'h0BAD_F00D, 5'd7);
    hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
    step("exstall", 6'b001111, 1'b0, bubble(64'h0000_0001_0000_0002, 2'b01));
    hilo_i = 64'h0000_0003_0000_0004; cnt_i = 2'b10;
    set_ex(32'h0000_0333, 5'd9);
    step("exrelease", 6'b000000, 1'b0, pass(32'h0000_0333, 5'd9));

    // MEM stall holds data and accumulator
    set_ex(32'h0000_00AA, 5'd2);
    step("load_aa", 6'b000000, 1'b0, pass(32'h0000_00AA, 5'd2));
    for (int i = 0; i < 3; i++) begin
      set_ex(32'h5000_0000 + 32'(i), 5'd4);
      step("memstall", 6'b011111, 1'b0, last);
    end

    // Accumulator held through a MEM stall that follows an EX stall
    hilo_i = 64'hCAFE_0000_0000_BABE; cnt_i = 2'b01;
    step("exstall2", 6'b001111, 1'b0, bubble(64'hCAFE_0000_0000_BABE, 2'b01));
    hilo_i = 64'h1111_1111_1111_1111; cnt_i = 2'b10;
    step("memstall_acc", 6'b011111, 1'b0, last);
    step("memstall_acc2", 6'b011111, 1'b0, last);

    // Flush beats both stall patterns
    set_ex(32'h0000_0800, 5'd3);
    step("flush_ex", 6'b001111, 1'b1, bubble(64'h0, 2'b00));
    set_ex(32'h7777_0001, 5'd6);
    step("pass3", 6'b000000, 1'b0, pass(32'h7777_0001, 5'd6));
    step("flush_mem", 6'b011111, 1'b1, bubble(64'h0, 2'b00));

    // EX running with only MEM flagged still loads
    set_ex(32'h2468_ACE0, 5'd12);
    step("mem_only", 6'b010000, 1'b0, pass(32'h2468_ACE0, 5'd12));

    // Reset mid-sequence clears the accumulator immediately
    hilo_i = 64'h0000_00FF_0000_00EE; cnt_i = 2'b01;
    step("exstall3", 6'b001111, 1'b0, bubble(64'h0000_00FF_0000_00EE, 2'b01));
    #3 rst = 1'b0;
    #1;
    exp_bc = 0;
    sb.push_back(bubble(64'h0, 2'b00));
    compare("reset_mid");
    #1 rst = 1'b1;

    // Four EX-stall bubbles then a flush: five bubbles counted
    cnt_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      hilo_i = 64'(i + 1);
      step("bubble_run", 6'b001111, 1'b0, bubble(64'(i + 1), 2'b01));
    end
    step("bubble_flush", 6'b001111, 1'b1, bubble(64'h0, 2'b00));
`ifdef EX_MEM_BUBBLE_CNT_EN
    chk("bubble_cnt_five", 64'(bubble_cnt_o), 64'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS core.
- Captures all execute-stage results: GPR writeback, HI/LO, load/store info, CP0 write, exception info.
- Honours the global stall vector and the exception flush.
- Holds the two-cycle MADD/MSUB accumulator state (hilo/cnt) and feeds it back to the execute stage while that stage is stalled.

Parameters:
DATA_W, 32, GPR/HI/LO/address width
ALUOP_W, 8, aluop field width
REGADDR_W, 5, GPR address width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
stall  in  6  global stall vector; bit3 = EX stalled, bit4 = MEM stalled
flush  in  1  exception flush from ctrl
ex_wd  in  REGADDR_W  destination GPR
ex_wreg  in  1  GPR write enable
ex_wdata  in  DATA_W  GPR write data
ex_hi / ex_lo  in  DATA_W each  HI/LO write data
ex_whilo  in  1  HI/LO write enable
ex_aluop  in  ALUOP_W  op code, for load/store decode
ex_mem_addr  in  DATA_W  effective address
ex_reg2  in  DATA_W  store data
ex_cp0_reg_we / ex_cp0_reg_write_addr / ex_cp0_reg_data  in  1/5/DATA_W  MTC0 write request
ex_excepttype  in  32  exception vector
ex_is_in_delayslot  in  1  delay-slot flag
ex_current_inst_address  in  DATA_W  instruction PC
hilo_i  in  2*DATA_W  partial product from EX (EX hilo_temp_o)
cnt_i  in  2  MADD/MSUB phase from EX (EX cnt_o)
mem_<field>  out  same width as matching ex_<field>  registered copy of each ex_ input above
hilo_o  out  2*DATA_W  to EX hilo_temp_i
cnt_o  out  2  to EX cnt_i

Behaviour:
- All state updates on the rising edge of clk. Latency is one cycle.
- Reset (rst=0, asynchronous) sets every output to 0: aluop = NOP (0), excepttype = 0, wreg/whilo/cp0_we = 0, hilo_o = 0, cnt_o = 0.
- Priority on each edge, highest first:
  1. flush=1: load a bubble. All mem_* outputs = 0, hilo_o = 0, cnt_o = 0. A flush overrides any stall.
  2. stall[3]=1 and stall[4]=0: load a bubble into mem_*. Capture hilo_o <= hilo_i and cnt_o <= cnt_i, so the accumulator survives the EX stall.
  3. stall[3]=0: load all mem_* from ex_*. Clear hilo_o and cnt_o to 0.
  4. stall[3]=1 and stall[4]=1: hold every register, including hilo_o and cnt_o.
- A bubble must never carry write enables (wreg, whilo, cp0_reg_we) or a nonzero excepttype.
- MADD/MSUB sequence:
  - Cycle 1: EX drives cnt=01 with stall[3]=1.
  - The block stores cnt_o=01 and hilo_o = partial product.
  - Cycle 2: EX completes and releases the stall.
  - The block then registers the final HI/LO and clears cnt_o to 00.
- No combinational path from any input to any output.
- Releasing reset mid-sequence restarts cleanly: cnt_o=0, so EX restarts the multiply-accumulate.

Optional Feature:
- Macro: EX_MEM_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt_o (32 bits). It increments on every edge where a bubble is inserted by rule 1 or rule 2, and wraps at 2^32 to 0. Reset value is 0. Used for stall-rate measurement.
- Undefined: the port and the counter are absent. Everything else is unchanged.

Decomposition:
- Shared defines package holds: RegBus/RegAddrBus/AluOpBus/DoubleRegBus widths, EXE_NOP_OP, WriteEnable/WriteDisable, Stop/NoStop, ZeroWord, and stall bit indices STALL_EX=3 and STALL_MEM=4.
- Flat module; no sub-module is warranted.

Test Plan:
- Reset: pulse rst=0 mid-cycle -> all outputs 0 immediately, without waiting for a clk edge.
- Pass-through: stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678 -> next edge mem_wd=5, mem_wreg=1, mem_wdata=0x1234_5678.
- EX stall: stall=6'b001111, cnt_i=01, hilo_i=0x0000_0001_0000_0002 -> mem_wreg=0, mem_aluop=0, hilo_o=0x0000_0001_0000_0002, cnt_o=01. Then stall=0 -> cnt_o=00, hilo_o=0.
- MEM stall: load wdata=0xAA, then stall=6'b011111 for 3 cycles with ex_wdata changing -> mem_wdata stays 0xAA and hilo_o/cnt_o are held.
- Flush beats stall: flush=1 with stall=6'b001111 and ex_excepttype=0x800 -> mem_excepttype=0, cnt_o=0, hilo_o=0.
- With EX_MEM_BUBBLE_CNT_EN defined: 4 EX-stall cycles followed by 1 flush -> bubble_cnt_o=5.
